// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_pkg;
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] PC_INC = 32'd4;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise it holds its contents.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] d_instr,
   input  logic [31:0] d_pc_plus4,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         pc_plus4 <= 32'h0;
      end else if (flush) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         pc_plus4 <= 32'h0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= d_instr;
         pc_plus4 <= d_pc_plus4;
      end
   end
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, imem handshake FSM and stall skid register feeding the IF/ID register.
module instruction_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic [5:0]  opcode,
   output logic [4:0]  inst_read_reg_addr1,
   output logic [4:0]  inst_read_reg_addr2,
   output logic [4:0]  rd,
   output logic [15:0] inst_imm_field,
   output logic [5:0]  funct
);
   state_t      state;
   logic [31:0] pc, pending_pc, skid_instr, skid_pc_plus4;
   logic [31:0] pc_next4, target;
   logic        redirect;
   logic        ld, fl;
   logic [31:0] d_instr, d_pc_plus4;

   assign redirect = branch_taken | jump;
   assign target   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
   assign pc_next4 = pc + PC_INC;

   // Gating with reset keeps the bus quiet for the whole reset window.
   assign imem_req  = reset & (state != HOLD);
   assign imem_addr = pc;

   always_comb begin
      ld         = 1'b0;
      fl         = 1'b0;
      d_instr    = imem_rdata;
      d_pc_plus4 = pc_next4;
      case (state)
         FETCH: begin
            if (redirect)        fl = 1'b1;
            else if (imem_ready) ld = !stall;
            else                 fl = !stall;
         end
         HOLD: begin
            if (redirect) fl = 1'b1;
            else if (!stall) begin
               ld         = 1'b1;
               d_instr    = skid_instr;
               d_pc_plus4 = skid_pc_plus4;
            end
         end
         default: fl = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         pending_pc    <= RESET_PC;
         skid_instr    <= NOP_INSTR;
         skid_pc_plus4 <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  if (redirect) pc <= target;
                  else begin
                     pc <= pc_next4;
                     if (stall) begin
                        skid_instr    <= imem_rdata;
                        skid_pc_plus4 <= pc_next4;
                        state         <= HOLD;
                     end
                  end
               end else if (redirect) begin
                  pending_pc <= target;
                  state      <= DRAIN;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (!stall) state <= FETCH;
            end
            DRAIN: begin
               // Address stays put until memory answers; the newest redirect wins.
               if (imem_ready) begin
                  pc    <= redirect ? target : pending_pc;
                  state <= FETCH;
               end else if (redirect) pending_pc <= target;
            end
            default: state <= FETCH;
         endcase
      end
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk        (clk),
      .reset      (reset),
      .load       (ld),
      .flush      (fl),
      .d_instr    (d_instr),
      .d_pc_plus4 (d_pc_plus4),
      .valid      (ifid_valid),
      .instr      (ifid_instr),
      .pc_plus4   (ifid_pc_plus4)
   );

   assign opcode              = ifid_instr[OPC_HI:OPC_LO];
   assign inst_read_reg_addr1 = ifid_instr[RS_HI:RS_LO];
   assign inst_read_reg_addr2 = ifid_instr[RT_HI:RT_LO];
   assign rd                  = ifid_instr[RD_HI:RD_LO];
   assign inst_imm_field      = ifid_instr[IMM_HI:IMM_LO];
   assign funct               = ifid_instr[FUNCT_HI:FUNCT_LO];
endmodule
